// File: rtl/icache_tag_port_sched.sv
// Tag-RAM port scheduler: arbitrates two write-buffer ports and a lookup port
// onto two tag arrays; a paired dual miss writes wb0 then wb1 back to back.
module icache_tag_port_sched #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_vld,
  output logic             lk_rdy,
  input  logic [IDX_W-1:0] lk_idx_a,
  input  logic [IDX_W-1:0] lk_idx_b,
  input  logic             lk_dual,
  input  logic             wb0_vld,
  output logic             wb0_rdy,
  input  logic             wb0_bank,
  input  logic [IDX_W-1:0] wb0_idx,
  input  logic [TAG_W-1:0] wb0_tag,
  input  logic             wb0_way,
  input  logic             wb1_vld,
  output logic             wb1_rdy,
  input  logic             wb1_bank,
  input  logic [IDX_W-1:0] wb1_idx,
  input  logic [TAG_W-1:0] wb1_tag,
  input  logic             wb1_way,
  input  logic             wb_pair,
  input  logic             stall,
  output logic             arr0_en,
  output logic             arr1_en,
  output logic             arr0_wr,
  output logic             arr1_wr,
  output logic [IDX_W-1:0] arr0_addr,
  output logic [IDX_W-1:0] arr1_addr,
  output logic [TAG_W:0]   wr_data,
  output logic             wr_way,
  output logic             rsp_vld,
  output logic             rsp_dual
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PAIR2 = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             gnt_wb0_s;
  logic             gnt_wb1_s;
  logic             lk_ok_s;
  logic             lk_go_s;
  logic             hazard_s;
  logic             wr_act_s;
  logic             wr_bank_s;
  logic             wr_way_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0] wr_tag_s;
  logic             rsp_vld_r;
  logic             rsp_dual_r;

  function automatic logic idx_hit(input logic vld, input logic [IDX_W-1:0] widx,
                                   input logic [IDX_W-1:0] ia, input logic [IDX_W-1:0] ib,
                                   input logic dual);
    return vld && ((widx == ia) || (dual && (widx == ib)));
  endfunction

  // Fixed-priority grant; in PAIR2 only the second half of the pair may proceed.
  // Grants are forced off while rst_n is low so every output reads 0 in reset.
  always_comb begin
    gnt_wb0_s = 1'b0;
    gnt_wb1_s = 1'b0;
    lk_ok_s   = 1'b0;
    hazard_s  = idx_hit(wb0_vld, wb0_idx, lk_idx_a, lk_idx_b, lk_dual) ||
                idx_hit(wb1_vld, wb1_idx, lk_idx_a, lk_idx_b, lk_dual);
    if (!rst_n) begin
      lk_ok_s = 1'b0;
    end else if (state_r == ST_PAIR2) begin
      gnt_wb1_s = wb1_vld;
    end else if (wb0_vld) begin
      gnt_wb0_s = 1'b1;
    end else if (wb1_vld) begin
      gnt_wb1_s = 1'b1;
    end else begin
      lk_ok_s = !stall && !hazard_s;
    end
  end

  assign lk_go_s  = lk_ok_s & lk_vld;
  assign wr_act_s = gnt_wb0_s | gnt_wb1_s;
  assign lk_rdy   = lk_ok_s;
  assign wb0_rdy  = gnt_wb0_s;
  assign wb1_rdy  = gnt_wb1_s;

  // Select the fields of whichever write port holds the grant.
  always_comb begin
    wr_bank_s = 1'b0;
    wr_idx_s  = {IDX_W{1'b0}};
    wr_tag_s  = {TAG_W{1'b0}};
    wr_way_s  = 1'b0;
    if (gnt_wb1_s) begin
      wr_bank_s = wb1_bank;
      wr_idx_s  = wb1_idx;
      wr_tag_s  = wb1_tag;
      wr_way_s  = wb1_way;
    end else if (gnt_wb0_s) begin
      wr_bank_s = wb0_bank;
      wr_idx_s  = wb0_idx;
      wr_tag_s  = wb0_tag;
      wr_way_s  = wb0_way;
    end else begin
      wr_bank_s = 1'b0;
    end
  end

  // Pair sequencing: wb_pair only matters on the cycle wb0 is actually granted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_wb0_s && wb_pair) begin
          state_nxt_s = ST_PAIR2;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAIR2: begin
        if (gnt_wb1_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_PAIR2;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // RAM control: a write touches only its bank; a lookup reads both arrays.
  always_comb begin
    arr0_en   = 1'b0;
    arr1_en   = 1'b0;
    arr0_wr   = 1'b0;
    arr1_wr   = 1'b0;
    arr0_addr = {IDX_W{1'b0}};
    arr1_addr = {IDX_W{1'b0}};
    wr_data   = {(TAG_W + 1){1'b0}};
    wr_way    = 1'b0;
    if (wr_act_s) begin
      if (wr_bank_s == 1'b0) begin
        arr0_en   = 1'b1;
        arr0_wr   = 1'b1;
        arr0_addr = wr_idx_s;
      end else begin
        arr1_en   = 1'b1;
        arr1_wr   = 1'b1;
        arr1_addr = wr_idx_s;
      end
      wr_data = {1'b1, wr_tag_s};
      wr_way  = wr_way_s;
    end else if (lk_go_s) begin
      arr0_en   = 1'b1;
      arr1_en   = 1'b1;
      arr0_addr = lk_idx_a;
      arr1_addr = lk_dual ? lk_idx_b : lk_idx_a;
    end else begin
      arr0_en = 1'b0;
    end
  end

  // Read data is valid one cycle after the lookup transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_r  <= 1'b0;
      rsp_dual_r <= 1'b0;
    end else begin
      rsp_vld_r  <= lk_go_s;
      rsp_dual_r <= lk_go_s & lk_dual;
    end
  end

  assign rsp_vld  = rsp_vld_r;
  assign rsp_dual = rsp_dual_r;

endmodule

// File: tb/tb_icache_tag_port_sched.sv
// Self-checking bench for icache_tag_port_sched: directed scenarios plus a
// randomized run against a cycle-level grant model.
module tb_icache_tag_port_sched;

  localparam int IDX_W = 6;
  localparam int TAG_W = 20;
  localparam int OW = 3 + 4 + 2 * IDX_W + TAG_W + 1 + 1 + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic lk_vld, lk_rdy, lk_dual;
  logic [IDX_W-1:0] lk_idx_a, lk_idx_b;
  logic wb0_vld, wb0_rdy, wb0_bank, wb0_way;
  logic wb1_vld, wb1_rdy, wb1_bank, wb1_way;
  logic [IDX_W-1:0] wb0_idx, wb1_idx;
  logic [TAG_W-1:0] wb0_tag, wb1_tag;
  logic wb_pair, stall;
  logic arr0_en, arr1_en, arr0_wr, arr1_wr;
  logic [IDX_W-1:0] arr0_addr, arr1_addr;
  logic [TAG_W:0] wr_data;
  logic wr_way, rsp_vld, rsp_dual;
  logic [OW-1:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  // model state: a pair half is outstanding; response expected this cycle
  bit m_pending = 1'b0;
  bit m_rsp = 1'b0;
  bit m_dual = 1'b0;

  always #5 clk = ~clk;

  icache_tag_port_sched #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_vld(lk_vld), .lk_rdy(lk_rdy), .lk_idx_a(lk_idx_a), .lk_idx_b(lk_idx_b), .lk_dual(lk_dual),
    .wb0_vld(wb0_vld), .wb0_rdy(wb0_rdy), .wb0_bank(wb0_bank), .wb0_idx(wb0_idx),
    .wb0_tag(wb0_tag), .wb0_way(wb0_way),
    .wb1_vld(wb1_vld), .wb1_rdy(wb1_rdy), .wb1_bank(wb1_bank), .wb1_idx(wb1_idx),
    .wb1_tag(wb1_tag), .wb1_way(wb1_way),
    .wb_pair(wb_pair), .stall(stall),
    .arr0_en(arr0_en), .arr1_en(arr1_en), .arr0_wr(arr0_wr), .arr1_wr(arr1_wr),
    .arr0_addr(arr0_addr), .arr1_addr(arr1_addr), .wr_data(wr_data), .wr_way(wr_way),
    .rsp_vld(rsp_vld), .rsp_dual(rsp_dual)
  );

  assign obs = {wb0_rdy, wb1_rdy, lk_rdy, arr0_en, arr1_en, arr0_wr, arr1_wr,
                arr0_addr, arr1_addr, wr_data, wr_way, rsp_vld, rsp_dual};

  task automatic clear_inputs();
    lk_vld = 1'b0; lk_dual = 1'b0; lk_idx_a = '0; lk_idx_b = '0;
    wb0_vld = 1'b0; wb0_bank = 1'b0; wb0_idx = '0; wb0_tag = '0; wb0_way = 1'b0;
    wb1_vld = 1'b0; wb1_bank = 1'b0; wb1_idx = '0; wb1_tag = '0; wb1_way = 1'b0;
    wb_pair = 1'b0; stall = 1'b0;
  endtask

  // Move to the next cycle: inputs change on the falling edge, checks run 2ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    wb0_vld = 1'b1; wb0_idx = 6'd9; wb0_tag = 20'hABCDE; wb_pair = 1'b1;
    lk_vld = 1'b1; lk_idx_a = 6'd3;
    next_cycle(); #2;
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", obs); end
    next_cycle();
    clear_inputs();
    rst_n = 1'b1;
    #2;
    n_cmp++;
    if (lk_rdy !== 1'b1) begin n_err++; $display("FAIL reset_release_lk_rdy: got %b want 1", lk_rdy); end
  endtask

  task automatic test_priority();
    next_cycle();
    clear_inputs();
    wb0_vld = 1'b1; wb0_bank = 1'b0; wb0_idx = 6'd10; wb0_tag = 20'h12345; wb0_way = 1'b1;
    wb1_vld = 1'b1; wb1_bank = 1'b1; wb1_idx = 6'd20; wb1_tag = 20'h54321; wb1_way = 1'b0;
    lk_vld = 1'b1; lk_idx_a = 6'd1; lk_idx_b = 6'd2;
    #2;
    n_cmp++;
    if ({wb0_rdy, wb1_rdy, lk_rdy, arr0_en, arr0_wr, arr1_en, arr0_addr, wr_data, wr_way} !==
        {3'b100, 3'b110, 6'd10, 1'b1, 20'h12345, 1'b1}) begin
      n_err++;
      $display("FAIL prio_cyc1_wb0: got rdy=%b%b%b en0=%b wr0=%b en1=%b a0=%0d wd=%h way=%b want wb0 write idx 10",
               wb0_rdy, wb1_rdy, lk_rdy, arr0_en, arr0_wr, arr1_en, arr0_addr, wr_data, wr_way);
    end
    next_cycle(); wb0_vld = 1'b0; #2;
    n_cmp++;
    if ({wb0_rdy, wb1_rdy, lk_rdy, arr0_en, arr1_en, arr1_wr, arr1_addr, arr0_addr, wr_data} !==
        {3'b010, 3'b011, 6'd20, 6'd0, 1'b1, 20'h54321}) begin
      n_err++;
      $display("FAIL prio_cyc2_wb1: got rdy=%b%b%b en=%b%b wr1=%b a1=%0d a0=%0d wd=%h want wb1 write idx 20",
               wb0_rdy, wb1_rdy, lk_rdy, arr0_en, arr1_en, arr1_wr, arr1_addr, arr0_addr, wr_data);
    end
    next_cycle(); wb1_vld = 1'b0; #2;
    n_cmp++;
    if ({lk_rdy, arr0_en, arr1_en, arr0_wr, arr1_wr, arr0_addr, arr1_addr, rsp_vld} !==
        {5'b11100, 6'd1, 6'd1, 1'b0}) begin
      n_err++;
      $display("FAIL prio_cyc3_lookup: got rdy=%b en=%b%b wr=%b%b a0=%0d a1=%0d rsp=%b want read idx 1",
               lk_rdy, arr0_en, arr1_en, arr0_wr, arr1_wr, arr0_addr, arr1_addr, rsp_vld);
    end
    next_cycle(); lk_vld = 1'b0; #2;
    n_cmp++;
    if ({rsp_vld, rsp_dual} !== 2'b10) begin
      n_err++; $display("FAIL prio_cyc4_rsp: got %b%b want 10", rsp_vld, rsp_dual);
    end
  endtask

  task automatic test_pair();
    next_cycle();
    clear_inputs();
    wb0_vld = 1'b1; wb_pair = 1'b1; wb0_bank = 1'b0; wb0_idx = 6'd30; wb0_tag = 20'h0AAAA; wb0_way = 1'b0;
    lk_vld = 1'b1; lk_idx_a = 6'd2;
    #2;
    n_cmp++;
    if ({wb0_rdy, lk_rdy, arr0_wr, arr0_addr, wr_way} !== {3'b101, 6'd30, 1'b0}) begin
      n_err++; $display("FAIL pair_wb0: got rdy=%b lk=%b wr0=%b a0=%0d way=%b want 1 0 1 30 0",
                        wb0_rdy, lk_rdy, arr0_wr, arr0_addr, wr_way);
    end
    next_cycle(); wb0_vld = 1'b0; wb_pair = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_cmp++;
      if ({lk_rdy, arr0_en, arr1_en} !== 3'b000) begin
        n_err++; $display("FAIL pair_wait_block: got lk_rdy=%b en=%b%b want 000", lk_rdy, arr0_en, arr1_en);
      end
      next_cycle();
    end
    wb1_vld = 1'b1; wb1_bank = 1'b0; wb1_idx = 6'd30; wb1_tag = 20'h0BBBB; wb1_way = 1'b1;
    #2;
    n_cmp++;
    if ({wb1_rdy, lk_rdy, arr0_wr, arr0_addr, wr_data, wr_way} !== {3'b101, 6'd30, 1'b1, 20'h0BBBB, 1'b1}) begin
      n_err++; $display("FAIL pair_wb1_same_slot: got rdy=%b lk=%b wr0=%b a0=%0d wd=%h way=%b want way 1 idx 30",
                        wb1_rdy, lk_rdy, arr0_wr, arr0_addr, wr_data, wr_way);
    end
    next_cycle(); wb1_vld = 1'b0; #2;
    n_cmp++;
    if ({lk_rdy, arr0_en, arr1_en, arr0_addr} !== {3'b111, 6'd2}) begin
      n_err++; $display("FAIL pair_lookup_after: got lk=%b en=%b%b a0=%0d want 1 11 2",
                        lk_rdy, arr0_en, arr1_en, arr0_addr);
    end
    next_cycle(); lk_vld = 1'b0;
  endtask

  task automatic test_hazard();
    clear_inputs();
    lk_vld = 1'b1; lk_idx_a = 6'd5;
    wb1_vld = 1'b1; wb1_bank = 1'b1; wb1_idx = 6'd5; wb1_tag = 20'h00555;
    #2;
    n_cmp++;
    if ({lk_rdy, wb1_rdy, arr1_wr, arr1_addr} !== {3'b011, 6'd5}) begin
      n_err++; $display("FAIL hazard_block: got lk=%b wb1=%b wr1=%b a1=%0d want 0 1 1 5",
                        lk_rdy, wb1_rdy, arr1_wr, arr1_addr);
    end
    next_cycle(); wb1_vld = 1'b0; #2;
    n_cmp++;
    if ({lk_rdy, arr0_en, arr0_addr} !== {2'b11, 6'd5}) begin
      n_err++; $display("FAIL hazard_release: got lk=%b en0=%b a0=%0d want 1 1 5", lk_rdy, arr0_en, arr0_addr);
    end
    next_cycle(); lk_vld = 1'b0;
  endtask

  task automatic test_dual();
    clear_inputs();
    lk_vld = 1'b1; lk_dual = 1'b1; lk_idx_a = 6'h3F; lk_idx_b = 6'h00;
    #2;
    n_cmp++;
    if ({arr0_en, arr1_en, arr0_wr, arr1_wr, arr0_addr, arr1_addr} !== {4'b1100, 6'h3F, 6'h00}) begin
      n_err++; $display("FAIL dual_read: got en=%b%b wr=%b%b a0=%h a1=%h want 11 00 3f 00",
                        arr0_en, arr1_en, arr0_wr, arr1_wr, arr0_addr, arr1_addr);
    end
    next_cycle(); clear_inputs(); #2;
    n_cmp++;
    if ({rsp_vld, rsp_dual} !== 2'b11) begin
      n_err++; $display("FAIL dual_rsp: got %b%b want 11", rsp_vld, rsp_dual);
    end
    next_cycle();
  endtask

  task automatic test_stall();
    clear_inputs();
    stall = 1'b1;
    wb0_vld = 1'b1; wb0_bank = 1'b1; wb0_idx = 6'd40; wb0_tag = 20'hF0F0F;
    lk_vld = 1'b1; lk_idx_a = 6'd7;
    #2;
    n_cmp++;
    if ({wb0_rdy, lk_rdy, arr1_wr, arr1_addr} !== {3'b101, 6'd40}) begin
      n_err++; $display("FAIL stall_write: got wb0=%b lk=%b wr1=%b a1=%0d want 1 0 1 40",
                        wb0_rdy, lk_rdy, arr1_wr, arr1_addr);
    end
    next_cycle(); wb0_vld = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++;
      if ({lk_rdy, arr0_en, arr1_en} !== 3'b000) begin
        n_err++; $display("FAIL stall_block: got lk=%b en=%b%b want 000", lk_rdy, arr0_en, arr1_en);
      end
      next_cycle();
    end
    stall = 1'b0; #2;
    n_cmp++;
    if ({lk_rdy, arr0_addr} !== {1'b1, 6'd7}) begin
      n_err++; $display("FAIL stall_release: got lk=%b a0=%0d want 1 7", lk_rdy, arr0_addr);
    end
    next_cycle(); lk_vld = 1'b0;
  endtask

  task automatic test_reset_mid_pair();
    clear_inputs();
    wb0_vld = 1'b1; wb_pair = 1'b1; wb0_idx = 6'd50; wb0_tag = 20'h11111;
    #2;
    n_cmp++;
    if (wb0_rdy !== 1'b1) begin n_err++; $display("FAIL rstpair_wb0: got %b want 1", wb0_rdy); end
    next_cycle();
    clear_inputs();
    wb1_vld = 1'b1; wb1_idx = 6'd51; lk_vld = 1'b1; lk_idx_a = 6'd4;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0) begin n_err++; $display("FAIL rstpair_outputs: got %h want 0", obs); end
    next_cycle();
    wb1_vld = 1'b0;
    rst_n = 1'b1;
    #2;
    n_cmp++;
    if ({lk_rdy, arr0_en, arr1_en, arr0_addr} !== {3'b111, 6'd4}) begin
      n_err++; $display("FAIL rstpair_lookup_first: got lk=%b en=%b%b a0=%0d want 1 11 4",
                        lk_rdy, arr0_en, arr1_en, arr0_addr);
    end
    next_cycle(); clear_inputs();
    next_cycle();
  endtask

  // Reference: who wins this cycle, and what the arrays must see as a result.
  task automatic model_expect(output logic [OW-1:0] e, output int win);
    bit haz, rdy, bank, en0, en1, wr0, wr1, way;
    logic [IDX_W-1:0] a0, a1, widx;
    logic [TAG_W:0] wd;
    haz = (wb0_vld && (wb0_idx == lk_idx_a || (lk_dual && wb0_idx == lk_idx_b))) ||
          (wb1_vld && (wb1_idx == lk_idx_a || (lk_dual && wb1_idx == lk_idx_b)));
    rdy = !m_pending && !wb0_vld && !wb1_vld && !stall && !haz;
    win = 3;
    if (m_pending) begin
      if (wb1_vld) win = 1;
    end else if (wb0_vld) win = 0;
    else if (wb1_vld) win = 1;
    else if (lk_vld && rdy) win = 2;
    en0 = 0; en1 = 0; wr0 = 0; wr1 = 0; a0 = '0; a1 = '0; wd = '0; way = 0;
    if (win < 2) begin
      bank = (win == 0) ? wb0_bank : wb1_bank;
      widx = (win == 0) ? wb0_idx : wb1_idx;
      wd = {1'b1, (win == 0) ? wb0_tag : wb1_tag};
      way = (win == 0) ? wb0_way : wb1_way;
      if (bank) begin en1 = 1; wr1 = 1; a1 = widx; end
      else begin en0 = 1; wr0 = 1; a0 = widx; end
    end else if (win == 2) begin
      en0 = 1; en1 = 1; a0 = lk_idx_a; a1 = lk_dual ? lk_idx_b : lk_idx_a;
    end
    e = {win == 0, win == 1, rdy, en0, en1, wr0, wr1, a0, a1, wd, way, m_rsp, m_dual};
  endtask

  task automatic test_random();
    logic [OW-1:0] exp_v;
    int win;
    clear_inputs();
    next_cycle();
    m_pending = 0; m_rsp = 0; m_dual = 0;
    for (int c = 0; c < 400; c++) begin
      wb0_vld = ($urandom_range(0, 9) < 3); wb0_bank = 1'($urandom_range(0, 1));
      wb0_idx = IDX_W'($urandom_range(0, 3)); wb0_tag = TAG_W'($urandom); wb0_way = 1'($urandom_range(0, 1));
      wb1_vld = ($urandom_range(0, 9) < 3); wb1_bank = 1'($urandom_range(0, 1));
      wb1_idx = IDX_W'($urandom_range(0, 3)); wb1_tag = TAG_W'($urandom); wb1_way = 1'($urandom_range(0, 1));
      wb_pair = 1'($urandom_range(0, 1)); stall = ($urandom_range(0, 9) < 2);
      lk_vld = ($urandom_range(0, 9) < 7); lk_dual = 1'($urandom_range(0, 1));
      lk_idx_a = IDX_W'($urandom_range(0, 7)); lk_idx_b = IDX_W'($urandom_range(0, 7));
      #2;
      model_expect(exp_v, win);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL random_cycle%0d: got %h want %h", c, obs, exp_v);
      end
      if (win == 0 && wb_pair) m_pending = 1;
      if (win == 1) m_pending = 0;
      m_rsp = (win == 2);
      m_dual = (win == 2) && lk_dual;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_pair();
    test_hazard();
    test_dual();
    test_stall();
    test_reset_mid_pair();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
